// File: rtl/fetch_queue_unit_pkg.sv
`default_nettype none
// ============================================================================
// fetch_queue_unit_pkg : shared fetch constants, queue entry type, PC helpers
// Rev 1.0
// ============================================================================
package fetch_queue_unit_pkg;

  localparam int INSTR_W    = 32;
  localparam int PAIR_BYTES = 8;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fq_entry_t;

  function automatic logic [31:0] pair_align(input logic [31:0] pc);
    return pc & ~32'(PAIR_BYTES - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pair_fifo.sv
`default_nettype none
// ============================================================================
// fetch_pair_fifo : circular instruction buffer, 0/1/2 push and pop per edge
// Rev 1.0
// ============================================================================
module fetch_pair_fifo
  import fetch_queue_unit_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic [1:0]         push_n_i,
  input  logic [INSTR_W-1:0] push0_instr_i,
  input  logic [31:0]        push0_pc_i,
  input  logic [INSTR_W-1:0] push1_instr_i,
  input  logic [31:0]        push1_pc_i,
  input  logic [1:0]         pop_n_i,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [31:0]        head_pc_o,
  output logic [INSTR_W-1:0] next_instr_o,
  output logic [CNT_W-1:0]   count_o
);

  fq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;

  assign head_p1 = head_q + PTR_W'(1);
  assign tail_p1 = tail_q + PTR_W'(1);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_n_i);
      tail_d  = tail_q + PTR_W'(push_n_i);
      count_d = count_q + CNT_W'(push_n_i) - CNT_W'(pop_n_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset: slots are only read once count covers them.
  always_ff @(posedge clk) begin
    if (!flush_i && push_n_i != 2'd0) begin
      mem_q[tail_q] <= '{instr: push0_instr_i, pc: push0_pc_i};
      if (push_n_i == 2'd2) begin
        mem_q[tail_p1] <= '{instr: push1_instr_i, pc: push1_pc_i};
      end
    end
  end

  assign head_instr_o = mem_q[head_q].instr;
  assign head_pc_o    = mem_q[head_q].pc;
  assign next_instr_o = mem_q[head_p1].instr;
  assign count_o      = count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !flush_i |-> (int'(count_q) + int'(push_n_i) - int'(pop_n_i) <= DEPTH));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !flush_i |-> (int'(pop_n_i) <= int'(count_q)));

endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// fetch_queue_unit : dual-wide fetch stage, PC/request control over pair queue
// Rev 1.0
// ============================================================================
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_req_valid,
  input  logic        icache_req_ready,
  output logic [31:0] icache_req_addr,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_instr1,
  input  logic [31:0] icache_resp_instr2,
  input  logic        rollback,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr1,
  output logic [31:0] instr2,
  output logic        instr1_valid,
  output logic        instr2_valid,
  output logic [31:0] pc1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             outstanding_q, outstanding_d;
  logic             drop_q, drop_d;

  logic [CNT_W-1:0] count;
  logic [31:0]      head_instr, head_pc, next_instr;
  logic [31:0]      resp_base;
  logic             space_ok, req_fire, resp_take;
  logic [1:0]       push_n, pop_n;

  assign space_ok         = (count <= CNT_W'(DEPTH - 2));
  assign icache_req_valid = !rst && !outstanding_q && space_ok && !redirect_valid;
  assign icache_req_addr  = pair_align(fetch_pc_q);
  assign req_fire         = icache_req_valid && icache_req_ready;
  assign resp_take        = icache_resp_valid && outstanding_q && !drop_q && !redirect_valid;
  assign resp_base        = pair_align(req_pc_q);

  // A request that started on the upper word of a pair only contributes that word.
  always_comb begin
    push_n = 2'd0;
    if (resp_take) begin
      push_n = req_pc_q[2] ? 2'd1 : 2'd2;
    end
  end

  always_comb begin
    pop_n = 2'd0;
    if (!redirect_valid && count != '0) begin
      pop_n = (rollback || count == CNT_W'(1)) ? 2'd1 : 2'd2;
    end
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (redirect_valid) begin
      fetch_pc_d    = redirect_pc & ~32'h3;
      outstanding_d = outstanding_q && !icache_resp_valid;
      drop_d        = outstanding_q && !icache_resp_valid;
    end else if (req_fire) begin
      outstanding_d = 1'b1;
      req_pc_d      = fetch_pc_q;
      fetch_pc_d    = pair_align(fetch_pc_q) + 32'(PAIR_BYTES);
    end else if (outstanding_q && icache_resp_valid) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= RESET_PC;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (redirect_valid),
    .push_n_i      (push_n),
    .push0_instr_i (req_pc_q[2] ? icache_resp_instr2 : icache_resp_instr1),
    .push0_pc_i    (req_pc_q[2] ? resp_base + 32'd4 : resp_base),
    .push1_instr_i (icache_resp_instr2),
    .push1_pc_i    (resp_base + 32'd4),
    .pop_n_i       (pop_n),
    .head_instr_o  (head_instr),
    .head_pc_o     (head_pc),
    .next_instr_o  (next_instr),
    .count_o       (count)
  );

  assign instr1_valid = (count != '0);
  assign instr2_valid = (count > CNT_W'(1));
  assign instr1       = instr1_valid ? head_instr : NOP_INSTR;
  assign instr2       = instr2_valid ? next_instr : NOP_INSTR;
  assign pc1          = instr1_valid ? head_pc : fetch_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue_unit : randomized bench against a queue-level fetch model
// Rev 1.0
// ============================================================================
module tb_fetch_queue_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_req_valid;
  logic        icache_req_ready;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_instr1;
  logic [31:0] icache_resp_instr2;
  logic        rollback;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr1, instr2, pc1;
  logic        instr1_valid, instr2_valid;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .DEPTH     (DEPTH),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .icache_req_valid   (icache_req_valid),
    .icache_req_ready   (icache_req_ready),
    .icache_req_addr    (icache_req_addr),
    .icache_resp_valid  (icache_resp_valid),
    .icache_resp_instr1 (icache_resp_instr1),
    .icache_resp_instr2 (icache_resp_instr2),
    .rollback           (rollback),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .instr1             (instr1),
    .instr2             (instr2),
    .instr1_valid       (instr1_valid),
    .instr2_valid       (instr2_valid),
    .pc1                (pc1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {word, pc} plus the fetch bookkeeping.
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_reqpc;
  bit          m_out, m_drop;

  // I-cache model
  bit          ic_pend;
  int          ic_wait, ic_minlat, ic_maxlat;
  logic [31:0] ic_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  function automatic bit model_req(input bit rd);
    return !m_out && (DEPTH - mq.size() >= 2) && !rd;
  endfunction

  task automatic check_outputs(input bit rd);
    check_eq("req_valid", 32'(icache_req_valid), 32'(model_req(rd)));
    check_eq("req_addr", icache_req_addr, m_pc & ~32'h7);
    check_eq("instr1_valid", 32'(instr1_valid), 32'(mq.size() >= 1));
    check_eq("instr2_valid", 32'(instr2_valid), 32'(mq.size() >= 2));
    if (mq.size() >= 1) begin
      check_eq("instr1", instr1, mq[0].instr);
      check_eq("pc1", pc1, mq[0].pc);
    end else begin
      check_eq("instr1", instr1, NOP);
      check_eq("pc1", pc1, m_pc);
    end
    if (mq.size() >= 2) check_eq("instr2", instr2, mq[1].instr);
    else                check_eq("instr2", instr2, NOP);
  endtask

  task automatic model_update(input bit rb, input bit rd, input logic [31:0] rdpc,
                              input bit acc, input bit rv,
                              input logic [31:0] r1, input logic [31:0] r2);
    logic [31:0] base;
    int n;
    if (rd) begin
      mq.delete();
      m_pc   = rdpc & ~32'h3;
      m_drop = m_out && !rv;
      m_out  = m_out && !rv;
    end else begin
      n = rb ? 1 : 2;
      if (n > mq.size()) n = mq.size();
      repeat (n) void'(mq.pop_front());
      if (m_out && rv) begin
        if (!m_drop) begin
          base = m_reqpc & ~32'h7;
          if (!m_reqpc[2]) mq.push_back('{r1, base});
          mq.push_back('{r2, base + 32'd4});
        end
        m_out  = 1'b0;
        m_drop = 1'b0;
      end else if (acc) begin
        m_out   = 1'b1;
        m_reqpc = m_pc;
        m_pc    = (m_pc & ~32'h7) + 32'd8;
      end
    end
  endtask

  task automatic step(input bit rb, input bit rd, input logic [31:0] rdpc,
                      input bit rdy, input bit stale);
    bit          rv, hit, acc, ev;
    logic [31:0] a, raddr;
    @(negedge clk);
    rollback         = rb;
    redirect_valid   = rd;
    redirect_pc      = rdpc;
    icache_req_ready = rdy;
    hit              = ic_pend && ic_wait == 0;
    rv               = hit || stale;
    a                = hit ? ic_addr : ($urandom & ~32'h7);
    icache_resp_valid  = rv;
    icache_resp_instr1 = mem_word(a);
    icache_resp_instr2 = mem_word(a + 32'd4);
    #1;
    check_outputs(rd);
    acc   = icache_req_valid && rdy;
    raddr = icache_req_addr;
    ev    = model_req(rd);
    @(posedge clk);
    model_update(rb, rd, rdpc, ev && rdy, rv, icache_resp_instr1, icache_resp_instr2);
    if (hit) ic_pend = 1'b0;
    else if (ic_pend) ic_wait--;
    if (acc) begin
      ic_pend = 1'b1;
      ic_addr = raddr;
      ic_wait = $urandom_range(ic_minlat, ic_maxlat);
    end
    #1;
  endtask

  task automatic apply_reset(input bit pulse);
    @(negedge clk);
    rst              = 1'b1;
    rollback         = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    icache_req_ready = 1'b1;
    icache_resp_valid  = pulse;
    icache_resp_instr1 = mem_word(ic_addr);
    icache_resp_instr2 = mem_word(ic_addr + 32'd4);
    #1;
    check_eq("rst_req_valid", 32'(icache_req_valid), 32'h0);
    check_eq("rst_req_addr", icache_req_addr, 32'h0);
    check_eq("rst_instr1", instr1, NOP);
    check_eq("rst_instr2", instr2, NOP);
    check_eq("rst_v1", 32'(instr1_valid), 32'h0);
    check_eq("rst_v2", 32'(instr2_valid), 32'h0);
    check_eq("rst_pc1", pc1, 32'h0);
    mq.delete();
    m_pc = 32'h0; m_reqpc = 32'h0; m_out = 1'b0; m_drop = 1'b0;
    ic_pend = 1'b0; ic_wait = 0;
    @(posedge clk);
    #1;
    icache_resp_valid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rollback = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    icache_req_ready = 1'b0; icache_resp_valid = 1'b0;
    icache_resp_instr1 = 32'h0; icache_resp_instr2 = 32'h0;
    ic_pend = 1'b0; ic_wait = 0; ic_addr = 32'h0; ic_minlat = 0; ic_maxlat = 0;
    apply_reset(1'b0);

    // 1-cycle I-cache latency from reset: first pair at 0x0
    step(0, 0, 32'h0, 1, 0);
    step(0, 0, 32'h0, 1, 0);
    check_eq("p_first_i1", instr1, mem_word(32'h0));
    check_eq("p_first_i2", instr2, mem_word(32'h4));
    check_eq("p_first_pc1", pc1, 32'h0);
    // rollback re-presents the second word
    step(1, 0, 32'h0, 1, 0);
    check_eq("p_rb_i1", instr1, mem_word(32'h4));
    check_eq("p_rb_pc1", pc1, 32'h4);
    check_eq("p_rb_v2", 32'(instr2_valid), 32'h0);
    // count=1 with rollback=0 pops only one, new pair lands behind it
    step(0, 0, 32'h0, 1, 0);
    check_eq("p_next_i1", instr1, mem_word(32'h8));
    check_eq("p_next_i2", instr2, mem_word(32'hC));
    step(0, 0, 32'h0, 1, 0);
    check_eq("p_empty_v1", 32'(instr1_valid), 32'h0);
    check_eq("p_empty_i1", instr1, NOP);
    check_eq("p_empty_pc1", pc1, 32'h18);

    // redirect while the 0x20 request is outstanding
    ic_minlat = 2; ic_maxlat = 2;
    for (int i = 0; i < 20 && !(m_out && m_reqpc == 32'h20); i++) step(0, 0, 32'h0, 1, 0);
    step(0, 1, 32'h0000_0105, 1, 0);
    ic_minlat = 0; ic_maxlat = 0;
    check_eq("p_redir_addr", icache_req_addr, 32'h100);
    check_eq("p_redir_pc1", pc1, 32'h104);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        step(0, 0, 32'h0, 1, 0);
        seen = instr1_valid;
      end
      check_eq("p_redir_seen", 32'(seen), 32'h1);
    end
    check_eq("p_redir_i1", instr1, mem_word(32'h104));
    check_eq("p_redir_pc1b", pc1, 32'h104);
    check_eq("p_redir_v2", 32'(instr2_valid), 32'h0);

    // reset while a response is arriving, then a stale pulse
    for (int i = 0; i < 10 && !m_out; i++) step(0, 0, 32'h0, 1, 0);
    apply_reset(1'b1);
    step(0, 0, 32'h0, 0, 1);
    check_eq("p_stale_v1", 32'(instr1_valid), 32'h0);
    check_eq("p_stale_pc1", pc1, 32'h0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0) begin
        ic_minlat = 0;
        ic_maxlat = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 399) == 0) apply_reset(ic_pend);
      else step($urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0,
                $urandom & 32'h0000_FFFF, $urandom_range(0, 3) != 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
